coefficient_buffer: RTL and testbench
=====================================

COEFFICIENT_BUFFER -- requirements
Module: coefficient_buffer

Interface
REQ-001 SHALL have parameter ORDER, default 12, number of LPC coefficients per block.
REQ-002 SHALL have parameter PRECISION, default 12, coefficient width in bits (two's complement).
REQ-003 SHALL have port iClock, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port iReset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port iEnable, input, 1, clock enable; low freezes all state and registered outputs.
REQ-006 SHALL have port iStart, input, 1, begin collection of a new coefficient block.
REQ-007 SHALL have port iValid, input, 1, iCoeff carries a quantized coefficient this cycle.
REQ-008 SHALL have port iCoeff, input, PRECISION, signed quantized coefficient from the quantizer stage, in order index 0..ORDER-1.
REQ-009 SHALL have port iAck, input, 1, consumer has taken the block and releases the buffer.
REQ-010 SHALL have port iReadAddr, input, 4, random-access read index.
REQ-011 SHALL have port oCoeffs, output, ORDER*PRECISION, slot k at bits [k*PRECISION +: PRECISION].
REQ-012 SHALL have port oReadCoeff, output, PRECISION, registered slot[iReadAddr].
REQ-013 SHALL have port oReady, output, 1, complete block held and stable.
REQ-014 SHALL have port oAllZero, output, 1, all ORDER slots equal zero; meaningful only while oReady=1.
REQ-015 SHALL have port oOverflow, output, 1, sticky: coefficient arrived while no slot was free.

Function
REQ-016 SHALL implement states IDLE, COLLECT, FULL; all transitions and captures only on cycles with iEnable=1.
REQ-017 IDLE: iValid without iStart SHALL be ignored (no write, no flag).
REQ-018 iStart in IDLE, COLLECT or FULL SHALL clear all slots to 0, clear count, clear oOverflow, and enter COLLECT.
REQ-019 iStart with iValid in the same cycle SHALL clear the other slots and write iCoeff to slot 0, count=1.
REQ-020 COLLECT: each iValid SHALL write iCoeff to slot[count] and increment count.
REQ-021 Writing slot ORDER-1 SHALL enter FULL; oReady SHALL be 1 from the next cycle.
REQ-022 FULL: slots SHALL be frozen; iValid SHALL drop the data and set oOverflow.
REQ-023 FULL with iAck (no iStart) SHALL go to IDLE; oReady=0 from the next cycle; slot contents retained.
REQ-024 iAck in IDLE or COLLECT SHALL be ignored.
REQ-025 iAck with iStart in FULL SHALL follow REQ-018 (iStart wins, back-to-back blocks).
REQ-026 oAllZero SHALL be registered and updated with slot writes, equal to the NOR of all slots.
REQ-027 oReadCoeff SHALL update one cycle after iReadAddr when iEnable=1; addresses >= ORDER SHALL give 0.
REQ-028 count SHALL never exceed ORDER-1 and SHALL never wrap.

Reset
REQ-029 iReset_n=0 SHALL asynchronously force: state IDLE, count 0, all slots 0, oReady 0, oOverflow 0, oReadCoeff 0, oAllZero 1.
REQ-030 Reset asserted mid-COLLECT SHALL discard the partial block; after release, collection restarts only on iStart.

Verification
REQ-031 iStart, then 12 iValid with coeffs 1..12 -> oReady=1 one cycle after the 12th; oCoeffs slot k = k+1; oAllZero=0.
REQ-032 FULL, iValid with coeff 0x7FF -> slots unchanged, oOverflow=1; then iAck -> oReady=0 next cycle; then iStart -> oOverflow=0.
REQ-033 12 coeffs with iEnable toggling every cycle -> captures only on enabled cycles, oReady after the 12th enabled iValid.
REQ-034 FULL with iAck and iStart+iValid(coeff -5) in the same cycle -> COLLECT, slot0=0xFFB, other slots 0, count 1, oReady=0.
REQ-035 iReset_n low after 5 coefficients -> all outputs at reset values immediately; later iValid without iStart -> no write.
REQ-036 iStart then 12 zero coeffs -> oReady=1, oAllZero=1; iReadAddr=13 -> oReadCoeff=0 next cycle.

Source files
------------

// File: rtl/coefficient_buffer.sv
// rtl/coefficient_buffer.sv - collects one block of quantized LPC coefficients and holds it for a consumer
//
// Purpose:
//   Coefficients arrive one per iValid, in index order 0..ORDER-1, after an iStart.
//   Once slot ORDER-1 is written, the block is frozen and oReady is raised.
//   The buffer stays frozen until the consumer acknowledges it with iAck, or until a new iStart.
//   Stray coefficients that arrive while the block is frozen are dropped.
//   They also raise the sticky oOverflow flag.
//
// Ports:
//   iClock      rising-edge clock for all state
//   iReset_n    asynchronous active-low reset
//   iEnable     clock enable; low freezes every register
//   iStart      begin a new block (clears slots, count and oOverflow)
//   iValid      iCoeff is valid this cycle
//   iCoeff      signed coefficient, PRECISION bits
//   iAck        consumer releases a full block
//   iReadAddr   random-access read index (4 bits, so ORDER <= 16)
//   oCoeffs     all slots flattened, slot k at [k*PRECISION +: PRECISION]
//   oReadCoeff  registered slot[iReadAddr], 0 for addresses >= ORDER
//   oReady      complete block held and stable
//   oAllZero    registered NOR of all slots
//   oOverflow   sticky: coefficient arrived while no slot was free

module coefficient_buffer #(
    parameter int ORDER     = 12,
    parameter int PRECISION = 12
) (
    input  logic                       iClock,
    input  logic                       iReset_n,
    input  logic                       iEnable,
    input  logic                       iStart,
    input  logic                       iValid,
    input  logic [PRECISION-1:0]       iCoeff,
    input  logic                       iAck,
    input  logic [3:0]                 iReadAddr,
    output logic [ORDER*PRECISION-1:0] oCoeffs,
    output logic [PRECISION-1:0]       oReadCoeff,
    output logic                       oReady,
    output logic                       oAllZero,
    output logic                       oOverflow
);

    localparam int CW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ORDER - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PRECISION-1:0] slots_q [ORDER];
    logic [PRECISION-1:0] slots_d [ORDER];
    logic                 overflow_q, overflow_d;
    logic                 all_zero_q, all_zero_d;
    logic [PRECISION-1:0] read_q, read_d;

    // Next-state, slot and flag logic. Nothing moves unless iEnable is high.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        slots_d    = slots_q;
        overflow_d = overflow_q;

        if (iEnable) begin
            if (iStart) begin
                // iStart wins over everything else, including iAck in FULL.
                // This lets blocks run back to back.
                for (int k = 0; k < ORDER; k++) begin
                    slots_d[k] = '0;
                end
                count_d    = '0;
                overflow_d = 1'b0;
                state_d    = COLLECT;
                if (iValid) begin
                    slots_d[0] = iCoeff;
                    if (LAST_IDX == '0) begin
                        state_d = FULL;
                    end else begin
                        count_d = CW'(1);
                    end
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // Without a preceding iStart, coefficients and acks are ignored.
                    end
                    COLLECT: begin
                        if (iValid) begin
                            for (int k = 0; k < ORDER; k++) begin
                                if (count_q == CW'(k)) begin
                                    slots_d[k] = iCoeff;
                                end
                            end
                            // The count saturates at the last index.
                            // The FULL state is what marks the block as complete.
                            if (count_q == LAST_IDX) begin
                                state_d = FULL;
                            end else begin
                                count_d = count_q + CW'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (iValid) begin
                            overflow_d = 1'b1;
                        end
                        if (iAck) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // The all-zero flag is computed from the slot values being written.
    // This keeps it aligned with the slot registers it describes.
    always_comb begin
        logic any_nonzero;
        any_nonzero = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            any_nonzero = any_nonzero | (|slots_d[k]);
        end
        all_zero_d = ~any_nonzero;
    end

    // Read port: out-of-range addresses match no slot and return zero.
    always_comb begin
        read_d = '0;
        for (int k = 0; k < ORDER; k++) begin
            if (iReadAddr == 4'(k)) begin
                read_d = slots_q[k];
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            all_zero_q <= 1'b1;
            read_q     <= '0;
            for (int k = 0; k < ORDER; k++) begin
                slots_q[k] <= '0;
            end
        end else if (iEnable) begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            all_zero_q <= all_zero_d;
            read_q     <= read_d;
            for (int k = 0; k < ORDER; k++) begin
                slots_q[k] <= slots_d[k];
            end
        end
    end

    for (genvar g = 0; g < ORDER; g++) begin : g_flatten
        assign oCoeffs[g*PRECISION +: PRECISION] = slots_q[g];
    end

    assign oReadCoeff = read_q;
    assign oReady     = (state_q == FULL);
    assign oAllZero   = all_zero_q;
    assign oOverflow  = overflow_q;

endmodule

// File: tb/tb_coefficient_buffer.sv
// tb/tb_coefficient_buffer.sv - directed self-checking bench for coefficient_buffer
module tb_coefficient_buffer;

    localparam int ORDER = 12;
    localparam int P     = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b1;
    logic             start = 1'b0;
    logic             valid = 1'b0;
    logic [P-1:0]     coeff = '0;
    logic             ack = 1'b0;
    logic [3:0]       raddr = '0;
    logic [ORDER*P-1:0] coeffs;
    logic [P-1:0]     rcoeff;
    logic             ready;
    logic             all_zero;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    coefficient_buffer #(.ORDER(ORDER), .PRECISION(P)) dut (
        .iClock     (clk),
        .iReset_n   (rst_n),
        .iEnable    (en),
        .iStart     (start),
        .iValid     (valid),
        .iCoeff     (coeff),
        .iAck       (ack),
        .iReadAddr  (raddr),
        .oCoeffs    (coeffs),
        .oReadCoeff (rcoeff),
        .oReady     (ready),
        .oAllZero   (all_zero),
        .oOverflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] slot(input int k);
        return coeffs[k*P +: P];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(input logic [P-1:0] c);
        valid = 1'b1;
        coeff = c;
        cyc();
        valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rd", rcoeff, 0);
        check("rst_allzero", all_zero, 1);
        check("rst_coeffs_lo", coeffs[31:0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Valid without start in IDLE is ignored
        feed(12'h123);
        check("idle_nowrite", slot(0), 0);
        check("idle_noovf", overflow, 0);

        // Block of 1..12
        do_start();
        for (int i = 0; i < ORDER; i++) begin
            feed(12'(i + 1));
            if (i == ORDER - 2) check("ready_before_last", ready, 0);
        end
        check("ready_after_12", ready, 1);
        check("allzero_block", all_zero, 0);
        check("slot0", slot(0), 1);
        check("slot5", slot(5), 6);
        check("slot11", slot(11), 12);
        raddr = 4'd3;
        cyc();
        check("read3", rcoeff, 4);
        raddr = 4'd11;
        cyc();
        check("read11", rcoeff, 12);
        raddr = 4'd13;
        cyc();
        check("read13_oob", rcoeff, 0);

        // Overflow in FULL, then ack, then start clears overflow
        feed(12'h7FF);
        check("ovf_set", overflow, 1);
        check("ovf_slot0_kept", slot(0), 1);
        check("ovf_slot11_kept", slot(11), 12);
        check("ovf_still_ready", ready, 1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        check("ack_ready0", ready, 0);
        check("ack_retained", slot(11), 12);
        check("ack_ovf_sticky", overflow, 1);
        feed(12'h055);
        check("idle_after_ack_nowrite", slot(0), 1);
        do_start();
        check("start_clr_ovf", overflow, 0);
        check("start_clr_slot", slot(11), 0);
        check("start_allzero", all_zero, 1);

        // Ack during COLLECT is ignored
        feed(12'h00A);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        feed(12'h00B);
        check("collect_ack_ignored", slot(1), 12'h00B);

        // Enable toggling: only even-step cycles are enabled
        do_start();
        valid = 1'b1;
        for (int i = 0; i < 2 * ORDER; i++) begin
            en = (i % 2 == 0);
            coeff = 12'(100 + i);
            cyc();
            if (i == 2 * ORDER - 3) check("en_ready_early", ready, 0);
        end
        valid = 1'b0;
        en = 1'b1;
        check("en_ready", ready, 1);
        check("en_slot0", slot(0), 100);
        check("en_slot1", slot(1), 102);
        check("en_slot11", slot(11), 122);
        en = 1'b0;
        start = 1'b1;
        raddr = 4'd1;
        cyc();
        start = 1'b0;
        check("en_freeze_ready", ready, 1);
        check("en_freeze_rd", rcoeff, 0);
        en = 1'b1;

        // FULL with ack + start + valid(-5)
        ack = 1'b1;
        start = 1'b1;
        valid = 1'b1;
        coeff = 12'hFFB;
        cyc();
        ack = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        check("bb_ready0", ready, 0);
        check("bb_slot0", slot(0), 12'hFFB);
        check("bb_slot1", slot(1), 0);
        check("bb_slot11", slot(11), 0);
        check("bb_allzero", all_zero, 0);
        for (int i = 1; i < ORDER; i++) begin
            feed(12'(i));
            if (i == ORDER - 2) check("bb_ready_early", ready, 0);
        end
        check("bb_ready_after11", ready, 1);
        check("bb_slot11_val", slot(11), 11);

        // Reset mid-collection
        do_start();
        for (int i = 0; i < 5; i++) feed(12'(7));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_slot0", slot(0), 0);
        check("mid_rst_allzero", all_zero, 1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_rd", rcoeff, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) feed(12'(9));
        check("post_rst_nowrite", slot(0), 0);
        check("post_rst_allzero", all_zero, 1);

        // All-zero block
        do_start();
        for (int i = 0; i < ORDER; i++) feed(12'(0));
        check("zero_ready", ready, 1);
        check("zero_allzero", all_zero, 1);
        raddr = 4'd13;
        cyc();
        check("zero_read13", rcoeff, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
